// File: rtl/pam_mod_if.sv
// pam_mod_if: AXI-stream word bus from the transmit FIFO into the PAM modulator.
interface pam_mod_if #(
    parameter int unsigned AXI_DATA_WIDTH = 32
);
    logic                        tvalid;
    logic                        tready;
    logic [AXI_DATA_WIDTH/8-1:0] tkeep;
    logic [AXI_DATA_WIDTH-1:0]   tdata;
    logic                        tlast;

    modport master (output tvalid, tkeep, tdata, tlast, input tready);
    modport slave  (input tvalid, tkeep, tdata, tlast, output tready);
endinterface

// File: rtl/pam_mod.sv
// pam_mod: PAM-16 modulator; unpacks AXI-stream words into signed DAC levels, MS nibble first.
// Optional per-frame pilot preamble is built when PAM_PILOT_EN is defined.
module pam_mod #(
    parameter int unsigned DA_CVER_WIDTH  = 12,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned PAM_ORDER      = 4,
    parameter int unsigned DATA_LEN       = 1024,
    parameter int unsigned PILOT_LEN      = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    pam_mod_if.slave                 s_axi,
    output logic                     o_mod_valid,
    output logic [DA_CVER_WIDTH-1:0] o_mod_data,
    output logic                     o_mod_sof,
    output logic                     o_mod_eof,
    output logic                     o_frame_err
);

    localparam int unsigned LVL_W      = DA_CVER_WIDTH + 1;
    localparam int unsigned SYM_PER_W  = AXI_DATA_WIDTH / PAM_ORDER;
    localparam int unsigned SYM_CNT_W  = (SYM_PER_W > 1) ? $clog2(SYM_PER_W) : 1;
    localparam int unsigned WORD_CNT_W = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;
    localparam int unsigned STEP       = ((32'd1 << DA_CVER_WIDTH) - 32'd1) /
                                         ((32'd1 << PAM_ORDER) - 32'd1);
    localparam int unsigned OFFSET     = 32'd1 << (DA_CVER_WIDTH - 1);

    localparam logic [SYM_CNT_W-1:0]  LAST_SYM  = SYM_CNT_W'(SYM_PER_W - 1);
    localparam logic [WORD_CNT_W-1:0] LAST_WORD = WORD_CNT_W'(DATA_LEN - 1);

`ifdef PAM_PILOT_EN
    localparam int unsigned           PILOT_CNT_W = (PILOT_LEN > 1) ? $clog2(PILOT_LEN) : 1;
    localparam logic [PILOT_CNT_W-1:0] LAST_PILOT = PILOT_CNT_W'(PILOT_LEN - 1);
    localparam logic [DA_CVER_WIDTH-1:0] LVL_MIN  = DA_CVER_WIDTH'(OFFSET);
    localparam logic [DA_CVER_WIDTH-1:0] LVL_MAX  = DA_CVER_WIDTH'(OFFSET - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PILOT = 2'd1,
        S_DATA  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA  = 2'd2
    } state_t;
`endif

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic [AXI_DATA_WIDTH-1:0] r_sreg;
    logic                      r_buf_vld;
    logic [SYM_CNT_W-1:0]      r_sym_cnt;
    logic                      r_last_flag;
    logic                      r_first;
    logic [WORD_CNT_W-1:0]     r_word_cnt;
`ifdef PAM_PILOT_EN
    logic [PILOT_CNT_W-1:0]    r_pilot_cnt;
`endif

    logic                      r_mod_valid;
    logic [DA_CVER_WIDTH-1:0]  r_mod_data;
    logic                      r_mod_sof;
    logic                      r_mod_eof;
    logic                      r_frame_err;

    logic                      w_ready;
    logic                      w_hs;
    logic                      w_sym_last;
    logic                      w_frame_close;
    logic                      w_new_frame;
    logic                      w_cnt_at_last;
    logic                      w_is_last;
    logic [PAM_ORDER-1:0]      w_sym;
    logic [LVL_W-1:0]          w_lvl_full;
    logic [DA_CVER_WIDTH-1:0]  w_level;
    logic                      w_valid_nxt;
    logic [DA_CVER_WIDTH-1:0]  w_data_nxt;
    logic                      w_sof_nxt;
    logic                      w_eof_nxt;
    logic                      w_unused_tkeep;

    assign w_unused_tkeep = ^s_axi.tkeep;

    assign w_sym_last    = (r_sym_cnt == LAST_SYM);
    assign w_frame_close = r_buf_vld && w_sym_last && r_last_flag;

    // Ready once the buffer is empty or about to emit its final symbol.
`ifdef PAM_PILOT_EN
    // Closing word never accepts a successor: every frame starts with its own pilot.
    assign w_ready = (r_state == S_DATA) &&
                     (!r_buf_vld || (w_sym_last && !r_last_flag));
`else
    assign w_ready = !r_buf_vld || w_sym_last;
`endif

    assign s_axi.tready  = w_ready && !i_rst;
    assign w_hs          = s_axi.tvalid && s_axi.tready;
    assign w_new_frame   = w_hs && ((r_state == S_IDLE) || r_last_flag);
    assign w_cnt_at_last = (r_word_cnt == LAST_WORD);
    assign w_is_last     = s_axi.tlast || w_cnt_at_last;

    // Level = k*STEP - 2^(W-1), computed one bit wider then truncated.
    assign w_sym      = r_sreg[AXI_DATA_WIDTH-1 -: PAM_ORDER];
    assign w_lvl_full = (LVL_W'(w_sym) * LVL_W'(STEP)) - LVL_W'(OFFSET);
    assign w_level    = w_lvl_full[DA_CVER_WIDTH-1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = 1'b0;
        w_data_nxt  = '0;
        w_sof_nxt   = 1'b0;
        w_eof_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
`ifdef PAM_PILOT_EN
                if (s_axi.tvalid) begin
                    w_state_nxt = S_PILOT;
                end
`else
                if (w_hs) begin
                    w_state_nxt = S_DATA;
                end
`endif
            end
`ifdef PAM_PILOT_EN
            S_PILOT: begin
                if (r_pilot_cnt == LAST_PILOT) begin
                    w_state_nxt = S_DATA;
                end
            end
`endif
            S_DATA: begin
                if (w_frame_close && !w_hs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

`ifdef PAM_PILOT_EN
        if (r_state == S_PILOT) begin
            w_valid_nxt = 1'b1;
            w_data_nxt  = r_pilot_cnt[0] ? LVL_MAX : LVL_MIN;
            w_sof_nxt   = (r_pilot_cnt == '0);
        end else
`endif
        if (r_buf_vld) begin
            w_valid_nxt = 1'b1;
            w_data_nxt  = w_level;
            w_sof_nxt   = r_first && (r_sym_cnt == '0);
            w_eof_nxt   = w_sym_last && r_last_flag;
        end
    end

    // Word buffer, symbol/word counters and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sreg      <= '0;
            r_buf_vld   <= 1'b0;
            r_sym_cnt   <= '0;
            r_last_flag <= 1'b0;
            r_first     <= 1'b0;
            r_word_cnt  <= '0;
            r_mod_valid <= 1'b0;
            r_mod_data  <= '0;
            r_mod_sof   <= 1'b0;
            r_mod_eof   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_mod_valid <= w_valid_nxt;
            r_mod_data  <= w_data_nxt;
            r_mod_sof   <= w_sof_nxt;
            r_mod_eof   <= w_eof_nxt;
            r_frame_err <= w_hs && (s_axi.tlast != w_cnt_at_last);

            if (w_hs) begin
                r_sreg      <= s_axi.tdata;
                r_buf_vld   <= 1'b1;
                r_sym_cnt   <= '0;
                r_last_flag <= w_is_last;
                r_first     <= w_new_frame;
                r_word_cnt  <= w_is_last ? '0 : r_word_cnt + WORD_CNT_W'(1);
            end else if (r_buf_vld) begin
                r_sreg    <= r_sreg << PAM_ORDER;
                r_sym_cnt <= r_sym_cnt + SYM_CNT_W'(1);
                if (w_sym_last) begin
                    r_buf_vld <= 1'b0;
                    if (r_last_flag) begin
                        r_last_flag <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef PAM_PILOT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pilot_cnt <= '0;
        end else if ((r_state == S_PILOT) && (r_pilot_cnt != LAST_PILOT)) begin
            r_pilot_cnt <= r_pilot_cnt + PILOT_CNT_W'(1);
        end else begin
            r_pilot_cnt <= '0;
        end
    end
`endif

    assign o_mod_valid = r_mod_valid;
    assign o_mod_data  = r_mod_data;
    assign o_mod_sof   = r_mod_sof;
    assign o_mod_eof   = r_mod_eof;
    assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_pam_mod.sv
// tb_pam_mod: directed bench for pam_mod; DUT A has DATA_LEN=1, DUT B has DATA_LEN=4.
module tb_pam_mod;

    typedef struct packed {
        logic        v;
        logic [11:0] d;
        logic        sof;
        logic        eof;
        logic        err;
        logic        rdy;
    } samp_t;

    typedef struct {
        logic [11:0] d;
        logic        sof;
        logic        eof;
    } ex_t;

    logic clk;
    logic rst;

    pam_mod_if #(.AXI_DATA_WIDTH(32)) if_a ();
    pam_mod_if #(.AXI_DATA_WIDTH(32)) if_b ();

    logic        a_valid, a_sof, a_eof, a_err;
    logic [11:0] a_data;
    logic        b_valid, b_sof, b_eof, b_err;
    logic [11:0] b_data;

    pam_mod #(.DATA_LEN(1)) u_dut_a (
        .i_clk       (clk),
        .i_rst       (rst),
        .s_axi       (if_a),
        .o_mod_valid (a_valid),
        .o_mod_data  (a_data),
        .o_mod_sof   (a_sof),
        .o_mod_eof   (a_eof),
        .o_frame_err (a_err)
    );

    pam_mod #(.DATA_LEN(4)) u_dut_b (
        .i_clk       (clk),
        .i_rst       (rst),
        .s_axi       (if_b),
        .o_mod_valid (b_valid),
        .o_mod_data  (b_data),
        .o_mod_sof   (b_sof),
        .o_mod_eof   (b_eof),
        .o_frame_err (b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed levels k*273-2048 as 12-bit two's complement.
    logic [11:0] lvl_tab [16] = '{12'h800, 12'h911, 12'hA22, 12'hB33,
                                  12'hC44, 12'hD55, 12'hE66, 12'hF77,
                                  12'h088, 12'h199, 12'h2AA, 12'h3BB,
                                  12'h4CC, 12'h5DD, 12'h6EE, 12'h7FF};

    int    checks = 0;
    int    errors = 0;
    bit    mon_sel = 1'b0;
    samp_t samp_a, samp_b;
    samp_t lg [$];
    ex_t   ex [$];

    assign samp_a = {a_valid, a_data, a_sof, a_eof, a_err, if_a.tready};
    assign samp_b = {b_valid, b_data, b_sof, b_eof, b_err, if_b.tready};

    always @(negedge clk) lg.push_back(mon_sel ? samp_b : samp_a);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? if_b.tready : if_a.tready;
    endfunction

    task automatic wait_rdy(input bit sel, input string tag);
        int n = 0;
        while (!rdy(sel) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $error("FAIL %s: tready observed 0 expected 1 within 200 cycles", tag);
        end
    endtask

    task automatic push_word(input bit sel, input logic [31:0] d, input bit last);
        if (sel) begin
            if_b.tvalid = 1'b1; if_b.tdata = d; if_b.tlast = last;
        end else begin
            if_a.tvalid = 1'b1; if_a.tdata = d; if_a.tlast = last;
        end
        wait_rdy(sel, "handshake");
        tick();
    endtask

    task automatic drop(input bit sel);
        if (sel) begin
            if_b.tvalid = 1'b0; if_b.tlast = 1'b0;
        end else begin
            if_a.tvalid = 1'b0; if_a.tlast = 1'b0;
        end
    endtask

    task automatic add_word(input logic [31:0] w, input bit sof, input bit eof);
        logic [31:0] s = w;
        for (int j = 0; j < 8; j++) begin
            ex.push_back('{d: lvl_tab[s[31:28]], sof: sof && (j == 0), eof: eof && (j == 7)});
            s = s << 4;
        end
    endtask

    task automatic add_pilot(input int n);
        for (int j = 0; j < n; j++)
            ex.push_back('{d: (j % 2 == 0) ? 12'h800 : 12'h7FF, sof: (j == 0), eof: 1'b0});
    endtask

    task automatic restart_log();
        lg.delete();
        ex.delete();
    endtask

    // Compare the logged output stream against the expected symbol list.
    task automatic check_log(input string tag, input int gaps_exp, input int errs_exp,
                             output int fv);
        int lv = -1, nv = 0, bad_d = 0, bad_s = 0, bad_e = 0, nz = 0, ne = 0;
        fv = -1;
        foreach (lg[i]) begin
            if (lg[i].err) ne++;
            if (lg[i].v) begin
                if (fv < 0) fv = i;
                lv = i;
                if (nv < ex.size()) begin
                    if (lg[i].d !== ex[nv].d)     bad_d++;
                    if (lg[i].sof !== ex[nv].sof) bad_s++;
                    if (lg[i].eof !== ex[nv].eof) bad_e++;
                end
                nv++;
            end else if (lg[i].d !== 12'h000 || lg[i].sof || lg[i].eof) begin
                nz++;
            end
        end
        chk({tag, " valid count"}, nv, ex.size());
        chk({tag, " gap cycles"}, (lv - fv + 1) - nv, gaps_exp);
        chk({tag, " level mismatches"}, bad_d, 0);
        chk({tag, " sof mismatches"}, bad_s, 0);
        chk({tag, " eof mismatches"}, bad_e, 0);
        chk({tag, " nonzero idle outputs"}, nz, 0);
        chk({tag, " frame_err pulses"}, ne, errs_exp);
    endtask

    initial begin
        int          fv;
        int          nr;
        logic [31:0] w [6];

        w[0] = 32'h89AB_CDEF;
        w[1] = 32'hFEDC_BA98;
        w[2] = 32'h0F1E_2D3C;
        w[3] = 32'h55AA_33CC;
        w[4] = 32'h1357_9BDF;
        w[5] = 32'h2468_ACE0;

        rst = 1'b1;
        if_a.tvalid = 1'b0; if_a.tkeep = '1; if_a.tdata = '0; if_a.tlast = 1'b0;
        if_b.tvalid = 1'b0; if_b.tkeep = '1; if_b.tdata = '0; if_b.tlast = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst tready a", if_a.tready, 1'b0);
        chk("rst tready b", if_b.tready, 1'b0);
        chk("rst outputs a", {a_valid, a_data, a_sof, a_eof, a_err}, '0);
        chk("rst outputs b", {b_valid, b_data, b_sof, b_eof, b_err}, '0);
        rst = 1'b0;
        tick();
`ifdef PAM_PILOT_EN
        chk("idle tready b", if_b.tready, 1'b0);

        // Pilot preamble, one-cycle gap, then a 4-word frame
        mon_sel = 1'b1;
        restart_log();
        push_word(1, w[0], 0);
        push_word(1, w[1], 0);
        push_word(1, w[2], 0);
        push_word(1, w[3], 1);
        drop(1);
        repeat (14) tick();
        add_pilot(16);
        add_word(w[0], 0, 0);
        add_word(w[1], 0, 0);
        add_word(w[2], 0, 0);
        add_word(w[3], 0, 1);
        check_log("pilot frame", 1, 0, fv);
        chk("pilot first symbol latency", fv, 2);
        chk("pilot idle tready after frame", if_b.tready, 1'b0);
`else
        chk("idle tready a", if_a.tready, 1'b1);
        chk("idle tready b", if_b.tready, 1'b1);

        // Single word, DATA_LEN=1
        mon_sel = 1'b0;
        restart_log();
        push_word(0, 32'h0123_4567, 1);
        drop(0);
        repeat (12) tick();
        add_word(32'h0123_4567, 1, 1);
        check_log("single word", 0, 0, fv);
        chk("single word latency", fv, 2);

        // Four words streamed gap-free
        mon_sel = 1'b1;
        restart_log();
        for (int i = 0; i < 4; i++) push_word(1, w[i], i == 3);
        drop(1);
        repeat (12) tick();
        for (int i = 0; i < 4; i++) add_word(w[i], i == 0, i == 3);
        check_log("stream4", 0, 0, fv);
        nr = 0;
        for (int i = 0; i < 24; i++) if (lg[fv + i].rdy) nr++;
        chk("stream4 tready per 24 symbols", nr, 3);
        chk("stream4 idle tready", if_b.tready, 1'b1);

        // Five-cycle underrun after the second word
        restart_log();
        push_word(1, w[0], 0);
        push_word(1, w[1], 0);
        drop(1);
        wait_rdy(1, "underrun wait");
        repeat (5) tick();
        push_word(1, w[2], 0);
        push_word(1, w[3], 1);
        drop(1);
        repeat (12) tick();
        for (int i = 0; i < 4; i++) add_word(w[i], i == 0, i == 3);
        check_log("underrun", 5, 0, fv);

        // Early tlast closes after word 2; missing tlast closes at word 4
        restart_log();
        push_word(1, w[0], 0);
        push_word(1, w[1], 1);
        for (int i = 2; i < 6; i++) push_word(1, w[i], 0);
        drop(1);
        repeat (12) tick();
        add_word(w[0], 1, 0);
        add_word(w[1], 0, 1);
        for (int i = 2; i < 6; i++) add_word(w[i], i == 2, i == 5);
        check_log("tlast errors", 0, 2, fv);

        // Reset during symbol 3 of the second word
        push_word(1, w[0], 0);
        push_word(1, w[1], 0);
        drop(1);
        repeat (4) tick();
        chk("pre-reset symbol 3 level", b_data, 12'h4CC);
        chk("pre-reset valid", b_valid, 1'b1);
        rst = 1'b1;
        tick();
        chk("mid-op reset outputs", {b_valid, b_data, b_sof, b_eof, b_err}, '0);
        chk("mid-op reset tready", if_b.tready, 1'b0);
        rst = 1'b0;
        tick();
        restart_log();
        push_word(1, 32'h0123_4567, 0);
        drop(1);
        repeat (12) tick();
        add_word(32'h0123_4567, 1, 0);
        check_log("after reset", 0, 0, fv);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
